sync_fifo_ctrl: RTL and testbench
=================================

Name: sync_fifo_ctrl

Overview:
Single-clock, parametrised successor to the team's dual-clock FIFO, for buffering inside one clock domain.
- Adds an occupancy count, runtime-programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush.
- FWFT parameter selects standard (registered read) or first-word-fall-through output mode.
- Storage is an internal register array; no CDC logic.

Parameters:
DEPTH, 512, number of entries; power of two, >= 4; ADDR_WIDTH = $clog2(DEPTH)
DATA_WIDTH, 8, word width in bits
FWFT, 0, 0 = standard mode (data one cycle after read), 1 = first-word-fall-through

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous reset, active-low (assert 0 -> immediate reset; deassert synchronous to clk)
w_en  input  1  write request
data_in  input  DATA_WIDTH  write data
r_en  input  1  read request (pop)
flush  input  1  synchronous clear of all contents and error flags
af_thresh  input  ADDR_WIDTH+1  almost-full threshold
ae_thresh  input  ADDR_WIDTH+1  almost-empty threshold
data_out  output  DATA_WIDTH  read data
rd_valid  output  1  data_out carries a newly popped word (FWFT=0); equals !empty (FWFT=1)
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= af_thresh
almost_empty  output  1  count <= ae_thresh
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset (rst=0, async): pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, data_out=0, rd_valid=0. Memory contents are not reset.
- Pointers: wptr/rptr are ADDR_WIDTH+1 bits; the MSB is the wrap bit.
  - full = (addr bits equal and MSBs differ).
  - empty = (pointers equal).
  - count = wptr - rptr, modulo 2^(ADDR_WIDTH+1).
- Write acceptance: w_en && !full && !flush. Writes data_in to mem[wptr] and increments wptr.
- Read acceptance: r_en && !empty && !flush. Increments rptr.
- Both decisions use the registered full/empty of the current cycle.
- Simultaneous write and read:
  - 0 < count < DEPTH: both accepted, count unchanged.
  - Full: read accepted, write rejected, overflow set.
  - Empty: write accepted, read rejected, underflow set.
- Errors: overflow <= 1 on w_en && full && !flush; underflow <= 1 on r_en && empty && !flush. Both hold until flush or reset; a rejected write never alters memory or pointers.
- FWFT=0 read path:
  - On an accepted read, data_out <= mem[rptr] at that edge (latency 1) and rd_valid = 1 for exactly one cycle.
  - Otherwise data_out holds its last value and rd_valid = 0.
- FWFT=1 read path:
  - data_out = mem[rptr] combinationally while !empty; data_out = 0 while empty.
  - rd_valid = !empty.
  - r_en pops the presented word; the next word appears in the following cycle.
  - A write into an empty FIFO becomes visible the cycle after the write edge.
- Flags:
  - full, empty, almost_full, almost_empty and count are registered and mutually consistent every cycle, all computed from next-state occupancy.
  - Thresholds are sampled each cycle; a threshold change is reflected in the flags one cycle later.
- Flush:
  - Priority over w_en/r_en in the same cycle.
  - Next edge: pointers=0, count=0, empty=1, full=0, overflow=0, underflow=0, rd_valid=0, almost_empty=1, almost_full=(af_thresh==0).
  - data_out is cleared in FWFT=0 mode.
- Wrap-around: pointers wrap modulo 2^(ADDR_WIDTH+1) with no gap; ordering is strictly preserved across any number of wraps.
- Reset mid-operation: async assertion immediately forces all reset values, and all stored data is treated as discarded.

Test Plan:
1. DEPTH=8, FWFT=0: assert rst=0 mid-burst, then release -> all outputs at reset values on the same cycle (empty=1, count=0, data_out=0); first write after release is accepted.
2. DEPTH=8, FWFT=0: write 0x01..0x08, then a 9th write 0xFF -> full=1 and count=8 after the 8th write; overflow=1 after the 9th. Eight reads -> data_out 0x01..0x08, each one cycle after its r_en with rd_valid pulsing; empty=1 afterwards. A further read -> underflow=1.
3. count=3: w_en=r_en=1 for 5 cycles -> count stays 3; outputs are the oldest words in order. At full with both asserted -> count=7, overflow=1.
4. Wrap: 20 write/read pairs with lag 5 on DEPTH=8 -> all 20 words read in order; pointer MSB toggles; no spurious full or empty.
5. af_thresh=6, ae_thresh=2, counting up from 0 -> almost_empty=1 for count 0..2 and clears at 3; almost_full sets at count 6. Change af_thresh to 8 -> almost_full clears the next cycle.
6. FWFT=1: single write 0xA5 into empty -> next cycle empty=0, data_out=0xA5 with no r_en. Then flush with w_en=1 and count=4 -> count=0, empty=1, overflow/underflow=0, data_out=0, and the write is ignored.

Source files
------------

// File: rtl/sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_ctrl
// Description : Single-clock FIFO controller with internal register storage,
//               occupancy count, programmable almost-full/almost-empty
//               thresholds, sticky overflow/underflow flags, synchronous
//               flush and a selectable standard / first-word-fall-through
//               read port.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_ctrl #(
    parameter  int DEPTH      = 512,  // power of two, >= 4
    parameter  int DATA_WIDTH = 8,
    parameter  int FWFT       = 0,    // 0: registered read, 1: fall-through
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,            // async, active-low
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  r_en,
    input  logic                  flush,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    // Pointers carry one extra wrap bit so that full and empty are
    // distinguishable when the address bits coincide.
    localparam int PTR_WIDTH = ADDR_WIDTH + 1;

    // ------------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_WIDTH-1:0]  wptr_q,  wptr_d;
    logic [PTR_WIDTH-1:0]  rptr_q,  rptr_d;
    logic [PTR_WIDTH-1:0]  count_q, count_d;
    logic                  full_q,   full_d;
    logic                  empty_q,  empty_d;
    logic                  afull_q,  afull_d;
    logic                  aempty_q, aempty_d;
    logic                  ovf_q,    ovf_d;
    logic                  udf_q,    udf_d;

    logic                  w_wr_accept;
    logic                  w_rd_accept;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [ADDR_WIDTH-1:0] w_raddr;
    logic [DATA_WIDTH-1:0] w_rdata;

    // ------------------------------------------------------------------------
    // Accept decisions use the registered flags of the current cycle; flush
    // overrides both requests.
    // ------------------------------------------------------------------------
    always_comb begin
        w_wr_accept = w_en && !full_q  && !flush;
        w_rd_accept = r_en && !empty_q && !flush;
    end

    assign w_waddr = wptr_q[ADDR_WIDTH-1:0];
    assign w_raddr = rptr_q[ADDR_WIDTH-1:0];
    assign w_rdata = mem_q[w_raddr];

    // Next-state pointers, occupancy and flags, all derived from the
    // next-state pointers so the registered flags stay mutually consistent.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (w_wr_accept) begin
                wptr_d = wptr_q + PTR_WIDTH'(1);
            end
            if (w_rd_accept) begin
                rptr_d = rptr_q + PTR_WIDTH'(1);
            end
        end

        // Modular subtraction gives the occupancy across any number of wraps.
        count_d  = wptr_d - rptr_d;
        empty_d  = (wptr_d == rptr_d);
        full_d   = (wptr_d[ADDR_WIDTH-1:0] == rptr_d[ADDR_WIDTH-1:0]) &&
                   (wptr_d[ADDR_WIDTH]     != rptr_d[ADDR_WIDTH]);
        // Thresholds are sampled here, so a change shows up one cycle later.
        afull_d  = (count_d >= af_thresh);
        aempty_d = (count_d <= ae_thresh);

        // Error flags are sticky until flush; flush wins over a new error.
        if (flush) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end else begin
            ovf_d = ovf_q || (w_en && full_q);
            udf_d = udf_q || (r_en && empty_q);
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage write; contents are not reset since the pointers alone define
    // which entries are live.
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            mem_q[w_waddr] <= data_in;
        end
    end

    // ------------------------------------------------------------------------
    // Read port
    // ------------------------------------------------------------------------
    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented combinationally; zero while empty keeps
            // stale storage contents off the bus.
            assign data_out = empty_q ? '0 : w_rdata;
            assign rd_valid = !empty_q;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] data_out_q;
            logic                  rd_valid_q;

            // Registered read: the popped word lands one cycle after r_en,
            // with rd_valid pulsing for that cycle only.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    data_out_q <= '0;
                    rd_valid_q <= 1'b0;
                end else if (flush) begin
                    data_out_q <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= w_rd_accept;
                    if (w_rd_accept) begin
                        data_out_q <= w_rdata;
                    end
                end
            end

            assign data_out = data_out_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Status outputs
    // ------------------------------------------------------------------------
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_ctrl
// Description : Self-checking bench for sync_fifo_ctrl (DEPTH=8) with one
//               standard-mode and one fall-through instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_ctrl;

    localparam int DEPTH = 8;
    localparam int DW    = 8;
    localparam int AW    = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    // Standard-mode instance
    logic          s_w_en = 0, s_r_en = 0, s_flush = 0;
    logic [DW-1:0] s_din = 0;
    logic [AW:0]   s_af = 4'd6, s_ae = 4'd2;
    logic [DW-1:0] s_dout;
    logic          s_rdv, s_full, s_empty, s_afull, s_aempty, s_ovf, s_udf;
    logic [AW:0]   s_cnt;

    // Fall-through instance
    logic          f_w_en = 0, f_r_en = 0, f_flush = 0;
    logic [DW-1:0] f_din = 0;
    logic [AW:0]   f_af = 4'd6, f_ae = 4'd2;
    logic [DW-1:0] f_dout;
    logic          f_rdv, f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
    logic [AW:0]   f_cnt;

    sync_fifo_ctrl #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .w_en(s_w_en), .data_in(s_din), .r_en(s_r_en),
        .flush(s_flush), .af_thresh(s_af), .ae_thresh(s_ae),
        .data_out(s_dout), .rd_valid(s_rdv), .full(s_full), .empty(s_empty),
        .almost_full(s_afull), .almost_empty(s_aempty), .count(s_cnt),
        .overflow(s_ovf), .underflow(s_udf)
    );

    sync_fifo_ctrl #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .w_en(f_w_en), .data_in(f_din), .r_en(f_r_en),
        .flush(f_flush), .af_thresh(f_af), .ae_thresh(f_ae),
        .data_out(f_dout), .rd_valid(f_rdv), .full(f_full), .empty(f_empty),
        .almost_full(f_afull), .almost_empty(f_aempty), .count(f_cnt),
        .overflow(f_ovf), .underflow(f_udf)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          w;
        logic [DW-1:0] d;
        logic          r;
        logic          fl;
        int            cnt;
        logic          fu;
        logic          em;
        logic [DW-1:0] dout;
        logic          rdv;
        logic          ovf;
        logic          udf;
        logic          af;
        logic          ae;
    } vec_t;

    vec_t tbl[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_std(input string tag, input int cnt, input logic fu, input logic em,
                             input logic [DW-1:0] dout, input logic rdv, input logic ovf,
                             input logic udf, input logic af, input logic ae);
        check({tag, ".count"},        32'(s_cnt),   32'(cnt));
        check({tag, ".full"},         32'(s_full),  32'(fu));
        check({tag, ".empty"},        32'(s_empty), 32'(em));
        check({tag, ".data_out"},     32'(s_dout),  32'(dout));
        check({tag, ".rd_valid"},     32'(s_rdv),   32'(rdv));
        check({tag, ".overflow"},     32'(s_ovf),   32'(ovf));
        check({tag, ".underflow"},    32'(s_udf),   32'(udf));
        check({tag, ".almost_full"},  32'(s_afull), 32'(af));
        check({tag, ".almost_empty"}, 32'(s_aempty),32'(ae));
    endtask

    // Reference model state for the randomized phase
    logic [DW-1:0] mq[$];
    logic          m_ovf, m_udf, m_rdv;
    logic [DW-1:0] m_dout;

    initial begin
        // ---------------- vector table: fill, overflow, drain, underflow ----
        tbl[0] = '{w:0, d:8'h00, r:0, fl:1, cnt:0, fu:0, em:1, dout:8'h00,
                   rdv:0, ovf:0, udf:0, af:0, ae:1};
        for (int i = 1; i <= 8; i++) begin
            tbl[i] = '{w:1, d:DW'(i), r:0, fl:0, cnt:i, fu:(i == 8), em:0, dout:8'h00,
                       rdv:0, ovf:0, udf:0, af:(i >= 6), ae:(i <= 2)};
        end
        tbl[9] = '{w:1, d:8'hFF, r:0, fl:0, cnt:8, fu:1, em:0, dout:8'h00,
                   rdv:0, ovf:1, udf:0, af:1, ae:0};
        for (int k = 1; k <= 8; k++) begin
            tbl[9+k] = '{w:0, d:8'h00, r:1, fl:0, cnt:8-k, fu:0, em:(k == 8), dout:DW'(k),
                         rdv:1, ovf:1, udf:0, af:((8-k) >= 6), ae:((8-k) <= 2)};
        end
        tbl[18] = '{w:0, d:8'h00, r:1, fl:0, cnt:0, fu:0, em:1, dout:8'h08,
                    rdv:0, ovf:1, udf:1, af:0, ae:1};

        // ---------------- reset state -------------------------------------
        repeat (2) tick();
        check_std("reset", 0, 0, 1, 8'h00, 0, 0, 0, 0, 1);
        rst = 1'b1;

        // ---------------- asynchronous reset mid-burst --------------------
        s_w_en = 1;
        for (int i = 0; i < 3; i++) begin
            s_din = 8'h21 + DW'(i);
            tick();
        end
        s_w_en = 0; s_r_en = 1;
        tick();
        check("burst.data_out", 32'(s_dout), 32'h21);
        check("burst.rd_valid", 32'(s_rdv), 32'h1);
        s_r_en = 0; s_w_en = 1; s_din = 8'h24;
        #2 rst = 1'b0;
        #1;
        check_std("async_rst", 0, 0, 1, 8'h00, 0, 0, 0, 0, 1);
        s_w_en = 0;
        tick();
        rst = 1'b1;
        s_w_en = 1; s_din = 8'h5A;
        tick();
        check("post_rst.count", 32'(s_cnt), 32'd1);
        check("post_rst.empty", 32'(s_empty), 32'd0);
        s_w_en = 0; s_r_en = 1;
        tick();
        check("post_rst.data_out", 32'(s_dout), 32'h5A);
        s_r_en = 0;

        // ---------------- table-driven fill / drain -----------------------
        for (int i = 0; i < 19; i++) begin
            s_w_en = tbl[i].w; s_din = tbl[i].d; s_r_en = tbl[i].r; s_flush = tbl[i].fl;
            tick();
            check_std($sformatf("tbl%0d", i), tbl[i].cnt, tbl[i].fu, tbl[i].em, tbl[i].dout,
                      tbl[i].rdv, tbl[i].ovf, tbl[i].udf, tbl[i].af, tbl[i].ae);
        end
        s_w_en = 0; s_r_en = 0; s_flush = 0;

        // ---------------- simultaneous read/write at count 3 and full -----
        s_flush = 1; tick(); s_flush = 0;
        s_w_en = 1;
        for (int i = 0; i < 3; i++) begin
            s_din = 8'h10 + DW'(i);
            tick();
        end
        s_r_en = 1;
        for (int i = 0; i < 5; i++) begin
            s_din = 8'h13 + DW'(i);
            tick();
            check($sformatf("rw%0d.count", i), 32'(s_cnt), 32'd3);
            check($sformatf("rw%0d.data_out", i), 32'(s_dout), 32'h10 + 32'(i));
            check($sformatf("rw%0d.rd_valid", i), 32'(s_rdv), 32'd1);
        end
        s_r_en = 0;
        for (int i = 0; i < 5; i++) begin
            s_din = 8'h18 + DW'(i);
            tick();
        end
        check("rw_fill.full", 32'(s_full), 32'd1);
        s_r_en = 1; s_din = 8'hEE;
        tick();
        check_std("rw_full", 7, 0, 0, 8'h15, 1, 1, 0, 1, 0);
        s_w_en = 0; s_r_en = 0;

        // ---------------- wrap-around with lag 5 --------------------------
        s_flush = 1; tick(); s_flush = 0;
        s_w_en = 1;
        for (int i = 0; i < 5; i++) begin
            s_din = 8'h40 + DW'(i);
            tick();
        end
        s_r_en = 1;
        for (int j = 0; j < 20; j++) begin
            s_w_en = (j < 15);
            s_din  = 8'h45 + DW'(j);
            tick();
            check($sformatf("wrap%0d.data_out", j), 32'(s_dout), 32'h40 + 32'(j));
            check($sformatf("wrap%0d.full", j), 32'(s_full), 32'd0);
            check($sformatf("wrap%0d.empty", j), 32'(s_empty), 32'(j == 19));
        end
        s_w_en = 0; s_r_en = 0;

        // ---------------- thresholds --------------------------------------
        s_af = 4'd6; s_ae = 4'd2;
        s_flush = 1; tick(); s_flush = 0;
        check("thr0.almost_empty", 32'(s_aempty), 32'd1);
        check("thr0.almost_full", 32'(s_afull), 32'd0);
        s_w_en = 1;
        for (int k = 1; k <= 7; k++) begin
            s_din = DW'(k);
            tick();
            check($sformatf("thr%0d.almost_empty", k), 32'(s_aempty), 32'(k <= 2));
            check($sformatf("thr%0d.almost_full", k), 32'(s_afull), 32'(k >= 6));
        end
        s_w_en = 0; s_af = 4'd8; s_ae = 4'd7;
        tick();
        check("thr_chg.almost_full", 32'(s_afull), 32'd0);
        check("thr_chg.almost_empty", 32'(s_aempty), 32'd1);
        check("thr_chg.count", 32'(s_cnt), 32'd7);

        // ---------------- randomized run against queue model --------------
        s_af = 4'd6; s_ae = 4'd2;
        s_flush = 1; tick(); s_flush = 0;
        mq.delete(); m_ovf = 0; m_udf = 0; m_rdv = 0; m_dout = '0;
        for (int c = 0; c < 400; c++) begin
            s_w_en  = ($urandom_range(0, 9) < 6);
            s_r_en  = ($urandom_range(0, 9) < 5);
            s_flush = ($urandom_range(0, 49) == 0);
            s_din   = DW'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                s_af = 4'($urandom_range(0, 9));
                s_ae = 4'($urandom_range(0, 9));
            end
            // model: what the FIFO must look like after this edge
            if (s_flush) begin
                mq.delete(); m_ovf = 0; m_udf = 0; m_rdv = 0; m_dout = '0;
            end else begin
                logic was_full, was_empty;
                was_full  = (mq.size() == DEPTH);
                was_empty = (mq.size() == 0);
                if (s_w_en && was_full)  m_ovf = 1;
                if (s_r_en && was_empty) m_udf = 1;
                m_rdv = s_r_en && !was_empty;
                if (m_rdv) m_dout = mq.pop_front();
                if (s_w_en && !was_full) mq.push_back(s_din);
            end
            tick();
            check_std($sformatf("rnd%0d", c), mq.size(), (mq.size() == DEPTH), (mq.size() == 0),
                      m_dout, m_rdv, m_ovf, m_udf, (mq.size() >= int'(s_af)),
                      (mq.size() <= int'(s_ae)));
        end
        s_w_en = 0; s_r_en = 0; s_flush = 0;

        // ---------------- fall-through mode -------------------------------
        f_r_en = 1;
        tick();
        check("fw_udf.underflow", 32'(f_udf), 32'd1);
        check("fw_udf.data_out", 32'(f_dout), 32'h0);
        check("fw_udf.rd_valid", 32'(f_rdv), 32'd0);
        f_r_en = 0; f_w_en = 1; f_din = 8'hA5;
        tick();
        f_w_en = 0;
        check("fw_first.empty", 32'(f_empty), 32'd0);
        check("fw_first.data_out", 32'(f_dout), 32'hA5);
        check("fw_first.rd_valid", 32'(f_rdv), 32'd1);
        f_w_en = 1;
        for (int i = 0; i < 3; i++) begin
            f_din = 8'hB6 + DW'(i * 17);
            tick();
        end
        f_w_en = 0;
        check("fw_fill.count", 32'(f_cnt), 32'd4);
        check("fw_fill.data_out", 32'(f_dout), 32'hA5);
        f_r_en = 1;
        tick();
        f_r_en = 0;
        check("fw_pop.data_out", 32'(f_dout), 32'hB6);
        check("fw_pop.count", 32'(f_cnt), 32'd3);
        f_w_en = 1; f_din = 8'hE9;
        tick();
        check("fw_refill.count", 32'(f_cnt), 32'd4);
        f_flush = 1; f_din = 8'h77;
        tick();
        f_flush = 0; f_w_en = 0;
        check("fw_flush.count", 32'(f_cnt), 32'd0);
        check("fw_flush.empty", 32'(f_empty), 32'd1);
        check("fw_flush.overflow", 32'(f_ovf), 32'd0);
        check("fw_flush.underflow", 32'(f_udf), 32'd0);
        check("fw_flush.data_out", 32'(f_dout), 32'h0);
        check("fw_flush.rd_valid", 32'(f_rdv), 32'd0);
        tick();
        check("fw_idle.count", 32'(f_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
